// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage controller between execute and a word-organised,
//   synchronous-read data memory. Decodes RISC-V load/store width from
//   funct3, produces the word address, byte enables and lane-shifted write
//   data, and extends load data. An access that straddles a word boundary
//   becomes two aligned memory transactions; the requester waits for the
//   response pulse.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req_valid     pipeline presents an access
//   req_ready     unit idle; request accepted this cycle if req_valid
//   req_we        1 = store, 0 = load
//   req_funct3    000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal
//   req_addr      byte address
//   req_wdata     store data, right-justified
//   resp_valid    one-cycle completion pulse
//   resp_rdata    extended load data (0 for stores, errors, idle)
//   resp_err      illegal funct3, valid with resp_valid
//   mem_en/mem_we memory access / write strobe
//   mem_addr      word-aligned address
//   mem_be        byte enables, bit i = lane i
//   mem_wdata     lane-aligned write data
//   mem_rdata     read word, valid the cycle after a read access
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t state, state_nxt;

  // Request captured at accept; data registers carry no reset.
  logic [WIDTH-1:0] addr_p0;
  logic [WIDTH-1:0] wdata_p0;
  logic             we_p0;
  logic [2:0]       f3_p0;
  logic             err_p0;
  // First word of a split load, captured while the second word is read.
  logic [WIDTH-1:0] rdata0_p1;

  logic [1:0]         off;
  logic [3:0]         size_be;
  logic [7:0]         be8;
  logic [WIDTH-1:0]   wmask;
  logic [2*WIDTH-1:0] d64;
  logic [2*WIDTH-1:0] r64;
  logic               split;
  logic [WIDTH-1:0]   waddr0;
  logic [WIDTH-1:0]   waddr1;

  // bu/hu have no store counterpart, so they are illegal with we=1.
  function automatic logic legal_f3(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = ~we;
      default:                legal_f3 = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Shift the gathered bytes down to bit 0 and extend to the access width.
  function automatic logic [WIDTH-1:0] extend_load(input logic [2*WIDTH-1:0] raw,
                                                   input logic [1:0]         sh_off,
                                                   input logic [2:0]         f3);
    logic [2*WIDTH-1:0] sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = raw >> {sh_off, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    case (f3)
      3'b000:  extend_load = WIDTH'(sb);
      3'b001:  extend_load = WIDTH'(shw);
      3'b100:  extend_load = WIDTH'(sh[7:0]);
      3'b101:  extend_load = WIDTH'(sh[15:0]);
      default: extend_load = sh[WIDTH-1:0];
    endcase
  endfunction

  assign off     = addr_p0[1:0];
  assign size_be = size_mask(f3_p0[1:0]);
  assign be8     = {4'b0000, size_be} << off;
  assign split   = |be8[7:4];
  assign wmask   = {{8{size_be[3]}}, {8{size_be[2]}}, {8{size_be[1]}}, {8{size_be[0]}}};
  assign d64     = {{WIDTH{1'b0}}, wdata_p0 & wmask} << {off, 3'b000};
  assign waddr0  = {addr_p0[WIDTH-1:2], 2'b00};
  assign waddr1  = waddr0 + WIDTH'(4);
  assign r64     = split ? {mem_rdata, rdata0_p1} : {{WIDTH{1'b0}}, mem_rdata};

  assign req_ready = (state == IDLE) & ~rst;

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      err_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        err_p0 <= ~legal_f3(req_we, req_funct3);
      end
    end
  end

  // Accepted request and first-word read data
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      we_p0    <= req_we;
      f3_p0    <= req_funct3;
    end
    if (state == ACC1) begin
      rdata0_p1 <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = legal_f3(req_we, req_funct3) ? ACC0 : DONE;
        end
      end
      ACC0: begin
        mem_en    = ~rst;
        mem_we    = we_p0 & ~rst;
        mem_addr  = waddr0;
        mem_be    = be8[3:0];
        mem_wdata = d64[WIDTH-1:0];
        state_nxt = split ? ACC1 : DONE;
      end
      ACC1: begin
        mem_en    = ~rst;
        mem_we    = we_p0 & ~rst;
        mem_addr  = waddr1;
        mem_be    = be8[7:4];
        mem_wdata = d64[2*WIDTH-1:WIDTH];
        state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_p0;
        if (!we_p0 && !err_p0) begin
          resp_rdata = extend_load(r64, off, f3_p0);
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Word-organised memory the DUT talks to (synchronous read).
  logic [31:0] wmem [logic [31:0]];

  always @(posedge clk) begin : mem_model
    logic [31:0] w;
    if (mem_en) begin
      w = wmem.exists(mem_addr) ? wmem[mem_addr] : 32'h0;
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        wmem[mem_addr] = w;
      end else begin
        mem_rdata <= w;
      end
    end
  end

  // Every memory transaction of the current request.
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } txn_t;
  txn_t txq[$];

  always @(negedge clk) begin
    if (mem_en) begin
      txq.push_back('{mem_addr, mem_be, mem_wdata, mem_we});
      check_eq("mem_addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
      check_eq("ready_while_busy", {31'b0, req_ready}, 32'h0);
    end
    if (!resp_valid) check_eq("rdata_idle_zero", resp_rdata, 32'h0);
  end

  // Reference model: a flat little-endian byte memory.
  logic [7:0] bmem [logic [31:0]];

  function automatic bit is_legal(input bit we, input logic [2:0] f3);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
  endfunction

  function automatic int nbytes_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v, ai;
    logic [7:0]  b;
    int          n;
    n = nbytes_of(f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      b  = bmem.exists(ai) ? bmem[ai] : 8'h00;
      v  = v | (32'(b) << (8 * i));
    end
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    for (int i = 0; i < nbytes_of(f3); i++) bmem[a + 32'(i)] = d[8*i +: 8];
  endtask

  task automatic preload(input logic [31:0] wa, input logic [31:0] word);
    wmem[wa] = word;
    for (int i = 0; i < 4; i++) bmem[wa + 32'(i)] = word[8*i +: 8];
  endtask

  logic [31:0] last_rdata;

  task automatic wait_ready(input string tag);
    int cnt = 0;
    while (!req_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
  endtask

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int          lat, exp_lat, nb;
    bit          legal;
    logic [31:0] exp_rd;
    wait_ready(tag);
    legal   = is_legal(we, f3);
    nb      = nbytes_of(f3);
    exp_lat = !legal ? 1 : ((int'(a[1:0]) + nb > 4) ? 3 : 2);
    exp_rd  = (legal && !we) ? ref_load(a, f3) : 32'h0;
    txq.delete();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    // Scramble inputs after accept; the unit must hold what it captured.
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'h1);
    check_eq({tag, "_resp_err"}, {31'b0, resp_err}, {31'b0, !legal});
    check_eq({tag, "_rdata"}, resp_rdata, exp_rd);
    check_eq({tag, "_ready_done"}, {31'b0, req_ready}, 32'h0);
    check_eq({tag, "_ntxn"}, txq.size(), legal ? exp_lat - 1 : 0);
    last_rdata = resp_rdata;
    if (legal && we) model_store(a, f3, d);
  endtask

  task automatic chk_tx(input string tag, input int idx, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input logic we);
    if (txq.size() > idx) begin
      check_eq({tag, "_addr"}, txq[idx].addr, a);
      check_eq({tag, "_be"}, {28'b0, txq[idx].be}, {28'b0, be});
      check_eq({tag, "_wdata"}, txq[idx].wdata, wd);
      check_eq({tag, "_we"}, {31'b0, txq[idx].we}, {31'b0, we});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'b0, req_ready}, 32'h0);
    check_eq("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_be", {28'b0, mem_be}, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", {31'b0, req_ready}, 32'h1);

    // 1: aligned word store/load
    do_req(1'b1, 3'b010, 32'h1000, 32'h12345678, "tp1_sw");
    chk_tx("tp1_sw_tx0", 0, 32'h1000, 4'b1111, 32'h12345678, 1'b1);
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, "tp1_lw");
    check_eq("tp1_lw_value", last_rdata, 32'h12345678);

    // 2: byte store at lane 3, signed/unsigned byte loads
    do_req(1'b1, 3'b000, 32'h1003, 32'h12345680, "tp2_sb");
    chk_tx("tp2_sb_tx0", 0, 32'h1000, 4'b1000, 32'h80000000, 1'b1);
    do_req(1'b0, 3'b000, 32'h1003, 32'h0, "tp2_lb");
    check_eq("tp2_lb_value", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h1003, 32'h0, "tp2_lbu");
    check_eq("tp2_lbu_value", last_rdata, 32'h00000080);

    // 3: misaligned word store split across two words
    do_req(1'b1, 3'b010, 32'h1002, 32'hAABBCCDD, "tp3_sw");
    chk_tx("tp3_sw_tx0", 0, 32'h1000, 4'b1100, 32'hCCDD0000, 1'b1);
    chk_tx("tp3_sw_tx1", 1, 32'h1004, 4'b0011, 32'h0000AABB, 1'b1);
    do_req(1'b0, 3'b010, 32'h1002, 32'h0, "tp3_lw");
    check_eq("tp3_lw_value", last_rdata, 32'hAABBCCDD);

    // 4: split halfword loads and address wrap
    preload(32'h1000, 32'h80112233);
    preload(32'h1004, 32'h445566FF);
    do_req(1'b0, 3'b001, 32'h1003, 32'h0, "tp4_lh");
    check_eq("tp4_lh_value", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 3'b101, 32'h1003, 32'h0, "tp4_lhu");
    check_eq("tp4_lhu_value", last_rdata, 32'h0000FF80);
    preload(32'hFFFFFFFC, 32'hCAFEBABE);
    preload(32'h00000000, 32'h76543210);
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, "tp4_lw_wrap");
    chk_tx("tp4_wrap_tx0", 0, 32'hFFFFFFFC, 4'b1100, 32'h0, 1'b0);
    chk_tx("tp4_wrap_tx1", 1, 32'h00000000, 4'b0011, 32'h0, 1'b0);
    check_eq("tp4_lw_wrap_value", last_rdata, 32'h3210CAFE);

    // 5: illegal funct3
    do_req(1'b0, 3'b011, 32'h1000, 32'h0, "tp5_illegal");
    do_req(1'b1, 3'b101, 32'h1000, 32'h5555AAAA, "tp5_st_hu");

    // 6: reset during the second half of a split store
    wait_ready("tp6");
    txq.delete();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1022; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("tp6_acc0_en", {31'b0, mem_en}, 32'h1);
    @(posedge clk); #1;
    check_eq("tp6_acc1_en", {31'b0, mem_en}, 32'h1);
    check_eq("tp6_acc1_addr", mem_addr, 32'h1024);
    rst = 1'b1;
    #1;
    check_eq("tp6_rst_mem_en", {31'b0, mem_en}, 32'h0);
    check_eq("tp6_rst_ready", {31'b0, req_ready}, 32'h0);
    check_eq("tp6_rst_resp", {31'b0, resp_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("tp6_no_resp", {31'b0, resp_valid}, 32'h0);
    end
    rst = 1'b0;
    #1;
    check_eq("tp6_ready_after_rst", {31'b0, req_ready}, 32'h1);
    // Only the first word was committed before the reset.
    bmem[32'h1022] = 8'hDD;
    bmem[32'h1023] = 8'hCC;
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, "tp6_lw");
    do_req(1'b0, 3'b010, 32'h1020, 32'h0, "tp6_lw_partial");
    do_req(1'b0, 3'b010, 32'h1024, 32'h0, "tp6_lw_untouched");

    // Randomized traffic against the byte-memory model
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                       : 32'h1000 + 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage controller between the execute stage (ALU result, RD2) and the word-organised data memory.
- Decodes RISC-V load/store width from funct3 and generates word address, byte enables and lane-shifted write data.
- Sign/zero-extends load data.
- Splits accesses that straddle a word boundary into two aligned memory transactions; the pipeline stalls until the response is returned.

Parameters:
WIDTH, 32, data/address width; the byte-lane logic is defined for 32 only.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  pipeline presents an access
req_ready  out  1  unit idle, request accepted this cycle if req_valid
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data (RD2), data in low bytes
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  32  extended load data; 0 for stores, errors and when resp_valid=0
resp_err  out  1  illegal funct3; valid with resp_valid
mem_en  out  1  memory access this cycle
mem_we  out  1  write strobe, qualified by mem_en
mem_addr  out  32  word-aligned address, bits [1:0] = 0
mem_be  out  4  byte enables, bit i = byte lane i
mem_wdata  out  32  lane-aligned write data
mem_rdata  in  32  read word, valid the cycle after a read access (synchronous read)

Behaviour:
- Reset values:
  - State is IDLE.
  - All outputs are 0 except req_ready.
  - req_ready = (state==IDLE) & ~rst, so it is 0 while rst is high.
  - rst takes effect immediately, including mid-access: mem_en drops combinationally and no resp_valid is produced for the aborted access.
- Accept:
  - Occurs when req_valid & req_ready at a rising edge.
  - addr, we, funct3 and wdata are registered at accept; later input changes are ignored until the next accept.
- Size: n = 1/2/4 bytes from funct3[1:0]; off = addr[1:0].
- Byte lanes:
  - be8 = ((1<<n)-1) << off; be0 = be8[3:0], be1 = be8[7:4].
  - split = (be1 != 0).
- Write data:
  - d64 = zero-extended (wdata masked to n bytes) << 8*off.
  - Word 0 uses d64[31:0]; word 1 uses d64[63:32].
- Addresses:
  - Word 0 address is {addr[31:2],2'b00}; word 1 address is word 0 + 4, modulo 2^32.
  - Example: addr 0xFFFFFFFE lw → word 1 address 0x00000000.
- FSM states: IDLE, ACC0, ACC1, DONE.
  - IDLE:
    - Legal request → ACC0.
    - Illegal funct3 → DONE with err flag set; no memory access.
  - ACC0:
    - mem_en=1, mem_we=we, word 0 address, be0, word 0 data.
    - Next state ACC1 if split, else DONE.
  - ACC1:
    - mem_en=1, mem_we=we, word 1 address, be1, word 1 data.
    - Registers mem_rdata (word 0 read data) into r0. Next state DONE.
  - DONE:
    - resp_valid=1. For loads, r64 = split ? {mem_rdata, r0} : {32'h0, mem_rdata}.
    - Load result = r64 >> 8*off, low n bytes, sign-extended for b/h and zero-extended for bu/hu/w.
    - Next state IDLE.
  - Outside ACC0/ACC1: mem_en, mem_we, mem_be and mem_wdata are all 0.
- Latency from accept edge to resp_valid:
  - 2 cycles unsplit.
  - 3 cycles split.
  - 1 cycle for an illegal funct3.
- Throughput: the next accept is possible in the cycle after DONE.
- Stores commit at the rising edge ending ACC0 (and ACC1 when split).
- Aligned word and byte accesses never split. A halfword at off=3 splits, as does a word at off≠0.
- resp_err=1 only for an illegal funct3. Loads with we=1 are not distinguished: funct3 alone selects the width for stores, and bu/hu encodings with we=1 are illegal.

Test Plan:
1. sw 0x12345678 @0x1000, then lw @0x1000 → store: ACC0 mem_be=1111, mem_wdata 0x12345678. Load: resp_rdata 0x12345678 with resp_valid 2 cycles after accept; req_ready low during ACC0/DONE.
2. sb 0x80 @0x1003 → mem_be=1000, mem_wdata 0x80000000. Then lb @0x1003 → 0xFFFFFF80; lbu @0x1003 → 0x00000080.
3. Misaligned sw 0xAABBCCDD @0x1002 → ACC0: addr 0x1000, be 1100, wdata 0xCCDD0000. ACC1: addr 0x1004, be 0011, wdata 0x0000AABB. Then lw @0x1002 → 0xAABBCCDD, latency 3.
4. Memory word 0x1000 = 0x80112233, word 0x1004 = 0x445566FF: lh @0x1003 → 0xFFFFFF80; lhu @0x1003 → 0x0000FF80. Then lw @0xFFFFFFFE → second access addr 0x00000000.
5. req_funct3=011 → mem_en never asserted; resp_valid with resp_err=1 and resp_rdata=0 one cycle after accept.
6. Split sw in flight, rst asserted during ACC1 → mem_en=0 immediately and no resp_valid. req_ready=1 in the first cycle after rst falls; the next lw @0x1000 completes normally.
